aes_round_ctrl: RTL

Iterative AES-128 encryption sequencer around the single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).
- Accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey.
- Drives the round datapath 10 times, generating each round key on the fly.
- Returns the ciphertext over a second valid/ready handshake.
- Sits between the host/bus interface and the round datapath.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_key_step.sv | 30 +++
 rtl/aes_round_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types and primitives for the iterative round controller:
// state/key types, FSM encoding, round-constant table and a computed S-box.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // Round constants for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (zero maps to zero), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key-schedule step: derives the next round key from
// the current one and that round's constant.
module aes_key_step
  import aes_pkg::*;
(
  input  key_t       key_i,
  input  logic [7:0] rcon_i,
  output key_t       key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] w4, w5, w6, w7;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign w4 = w0 ^ sub ^ {rcon_i, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign key_o = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: accepts a block, performs the
// initial AddRoundKey, drives an external round datapath ten times with
// on-the-fly round keys, then presents the ciphertext.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_LAT = 1,
  parameter int NROUNDS   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] rnd_data,
  output logic [127:0] rnd_key,
  output logic         rnd_final,
  output logic         rnd_start,
  input  logic [127:0] rnd_result,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam int              WCW      = (ROUND_LAT < 2) ? 1 : $clog2(ROUND_LAT + 1);
  localparam logic [WCW-1:0]  WLAST    = WCW'(ROUND_LAT);
  localparam logic [3:0]      LAST_RND = 4'(NROUNDS);

  fsm_e           state_q, state_d;
  state_t         data_q,  data_d;
  key_t           key_q,   key_d;
  logic [3:0]     rc_q,    rc_d;
  logic [WCW-1:0] wcnt_q,  wcnt_d;

  key_t       key_src;
  key_t       key_next;
  logic [7:0] rcon_sel;

  // A single key-step unit serves both the accept cycle (from the cipher key)
  // and every round transition (from the held round key).
  always_comb begin
    key_src  = key_q;
    rcon_sel = rcon(rc_q + 4'd1);
    if (state_q == IDLE) begin
      key_src  = in_key;
      rcon_sel = rcon(4'd1);
    end
  end

  aes_key_step u_key_step (
    .key_i  (key_src),
    .rcon_i (rcon_sel),
    .key_o  (key_next)
  );

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rc_d    = rc_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data ^ in_key;
          key_d   = key_next;
          rc_d    = 4'd1;
          wcnt_d  = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (wcnt_q == WLAST) begin
          data_d = rnd_result;
          wcnt_d = '0;
          if (rc_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            key_d = key_next;
            rc_d  = rc_q + 4'd1;
          end
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          rc_d    = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rc_q    <= 4'd0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Gating with rst_n keeps the host from seeing a ready controller while
  // it is still held in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign rnd_data  = data_q;
  assign rnd_key   = key_q;
  assign rnd_final = (state_q == ROUND) && (rc_q == LAST_RND);
  assign rnd_start = (state_q == ROUND) && (wcnt_q == '0);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign round_cnt = rc_q;

endmodule
